full_adder_4bit_bh: RTL and testbench
=====================================

# full_adder_4bit_bh

4-bit binary adder computing a + b + ci, with a zero-latency combinational sum/carry and a one-cycle registered copy of the result. It is a leaf arithmetic block for datapaths that need an unsigned 4-bit add with carry-in/carry-out, or a signed add with overflow detection. The combinational outputs are the primary function. The registered outputs serve pipelined consumers.

## Interface
Parameters:
- WIDTH, 4, operand width. Only 4 is supported and verified; other values are out of scope.

Ports (instantiation order: s, co, a, b, ci, clk, rst):
- clk  input  1  single clock; rising-edge active; drives only the registered outputs
- rst  input  1  reset, asynchronous, active-high; clears registered outputs only
- s  output  4  combinational sum bits [3:0] of a + b + ci
- co  output  1  combinational carry-out (bit 4 of a + b + ci)
- a  input  4  operand A, unsigned, or two's complement for ovf
- b  input  4  operand B, unsigned, or two's complement for ovf
- ci  input  1  carry-in
- s_q  output  4  registered s
- co_q  output  1  registered co
- ovf_q  output  1  registered signed overflow flag

## Operation
- Arithmetic: the full 5-bit result {co, s} equals a + b + ci, with zero-extension to 5 bits before the add. This covers all 512 input combinations with no saturation.
- Combinational outputs s and co follow the inputs with no storage, are independent of clk, and are unaffected by rst.
- Signed overflow: ovf = (a[3] == b[3]) && (s[3] != a[3]). It is computed combinationally and exposed only as ovf_q.
- Internal structure: four 1-bit full-adder cells chained as a ripple carry. Cell i has sum = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]). c[0] = ci and co = c[4].
- The ripple output must be bit-identical to the behavioral a + b + ci. An internal consistency assertion checks this in simulation only.
- Registered stage: on each rising clk edge, s_q, co_q and ovf_q capture s, co and ovf respectively.
- There is no enable and no valid handshake; the registers sample every cycle.

## Timing
- s and co have zero-cycle latency and settle within one combinational propagation, with the worst path being ci through c4.
- s_q, co_q and ovf_q have one-cycle latency: inputs stable before edge N appear on these outputs after edge N.
- Reset values: s_q = 4'b0000, co_q = 0, ovf_q = 0.
- Reset is asynchronous: asserting rst clears the registered outputs immediately, independent of clk.
- While rst is high, the registers hold their reset values.
- Deassertion is synchronous in effect: the first capture occurs on the first rising edge with rst low.
- Reset asserted mid-stream: the registered outputs clear at once, while s and co keep tracking the inputs.
- Simultaneous rst and clk edge: reset wins.
- Input change without a clock edge: s and co update, while the registered outputs hold.

## Structure
- Sub-module full_adder_1bit (a, b, ci, s, co) is instantiated four times via generate.
- A shared package holds the WIDTH default constant and a 5-bit result typedef ({carry, sum}) for consumers of the registered outputs.
- The top level contains the carry chain, the overflow logic, the output register bank, and the simulation-only check of ripple versus behavioral sum.

## Test plan
- Exhaustive sweep: step a, b and ci over all 512 combinations with 10 ns spacing. At each step, {co, s} must equal a + b + ci; for example, a=0101, b=0011, ci=1 gives s=1001, co=0.
- Carry boundaries:
  - a=1111, b=0001, ci=0 gives s=0000, co=1.
  - a=1111, b=1111, ci=1 gives s=1111, co=1.
  - a=0, b=0, ci=0 gives s=0000, co=0.
- Signed overflow:
  - a=0111, b=0001, ci=0 gives s=1000, co=0, and ovf_q=1 after the next edge.
  - a=1000, b=1000, ci=0 gives s=0000, co=1, and ovf_q=1.
  - a=1111, b=0001 gives ovf_q=0.
- Register latency: apply a=0011, b=0100, ci=0 before edge N. Then s=0111 immediately, and s_q=0111, co_q=0 after edge N but not before.
- Asynchronous reset:
  - With s_q=1111, co_q=1, pulse rst between clock edges. s_q, co_q and ovf_q must go to 0 without waiting for a clock edge, while s and co are unchanged.
  - After rst falls, the next edge reloads the registers.
- Carry chain: a=1111, b=0000, toggle ci 0 to 1. s must go from 1111 to 0000 and co from 0 to 1, which exercises the full ripple path.

Source files
------------

// File: rtl/full_adder_4bit_bh_pkg.sv
// Shared constants and result type for the 4-bit ripple adder and its consumers.
package full_adder_4bit_bh_pkg;

    localparam int WIDTH_DEF = 4;

    // {carry, sum} view of the registered adder outputs.
    typedef struct packed {
        logic                 carry;
        logic [WIDTH_DEF-1:0] sum;
    } add_result_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Single full-adder cell; one link of the ripple carry chain.
module full_adder_1bit
    import full_adder_4bit_bh_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder_4bit_bh.sv
// 4-bit ripple-carry adder with combinational sum/carry and a registered
// copy of sum, carry and signed overflow.
module full_adder_4bit_bh
    import full_adder_4bit_bh_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)(
    output logic [WIDTH-1:0] s,
    output logic             co,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] s_q,
    output logic             co_q,
    output logic             ovf_q
);

    logic [WIDTH:0]   c;
    logic [WIDTH:0]   beh_sum;
    logic             ovf;

    assign c[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_1bit u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[WIDTH];

    // Overflow only possible when operands share a sign and the sum flips it.
    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            s_q   <= s;
            co_q  <= co;
            ovf_q <= ovf;
        end
    end

    // Behavioral reference for the ripple chain; never reaches a netlist.
    assign beh_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

    always_comb begin
        assert ({co, s} == beh_sum);
    end

endmodule

// File: tb/tb_full_adder_4bit_bh.sv
// Randomized and directed checks of full_adder_4bit_bh against an integer model.
module tb_full_adder_4bit_bh;

    logic [3:0] a, b, s, s_q;
    logic       ci, co, co_q, ovf_q;
    logic       clk, rst;

    int n_vec = 0;
    int n_err = 0;
    logic [5:0] prev_reg;

    full_adder_4bit_bh #(.WIDTH(4)) dut (
        .s     (s),
        .co    (co),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .clk   (clk),
        .rst   (rst),
        .s_q   (s_q),
        .co_q  (co_q),
        .ovf_q (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s a=%h b=%h ci=%b: got %h expected %h", tag, a, b, ci, got, exp);
        end
    endtask

    // Returns {ovf, co, s[3:0]} from plain unsigned and signed arithmetic.
    function automatic logic [5:0] ref_add(input int ua, input int ub, input int uci);
        int u, sa, sb, sr;
        logic [5:0] r;
        u  = ua + ub + uci;
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        sr = sa + sb + uci;
        r[4:0] = u[4:0];
        r[5]   = (sr > 7) || (sr < -8);
        return r;
    endfunction

    // Called just after a rising edge; one vector per clock period.
    task automatic step(input logic [3:0] ta, input logic [3:0] tb_v, input logic tci);
        logic [5:0] e;
        a = ta; b = tb_v; ci = tci;
        e = ref_add(int'(ta), int'(tb_v), int'(tci));
        #1;
        check("comb", {3'b000, co, s}, {3'b000, e[4:0]});
        check("hold", {2'b00, ovf_q, co_q, s_q}, {2'b00, prev_reg});
        @(posedge clk); #1;
        check("reg", {2'b00, ovf_q, co_q, s_q}, {2'b00, e});
        prev_reg = e;
    endtask

    initial begin
        rst = 1'b0; a = 4'h5; b = 4'ha; ci = 1'b1;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_val", {2'b00, ovf_q, co_q, s_q}, 8'h00);
        check("comb_in_reset", {3'b000, co, s}, 8'h10);
        rst = 1'b0;
        prev_reg = 6'h00;

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step(v[8:5], v[4:1], v[0]);
        end

        step(4'b0101, 4'b0011, 1'b1);
        step(4'b1111, 4'b0001, 1'b0);
        step(4'b1111, 4'b1111, 1'b1);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0111, 4'b0001, 1'b0);
        check("ovf_pos", {7'd0, ovf_q}, 8'h01);
        step(4'b1000, 4'b1000, 1'b0);
        check("ovf_neg", {7'd0, ovf_q}, 8'h01);
        step(4'b1111, 4'b0001, 1'b1);
        check("ovf_none", {7'd0, ovf_q}, 8'h00);
        step(4'b0011, 4'b0100, 1'b0);
        check("latency_s_q", {4'h0, s_q}, 8'h07);

        // Asynchronous reset pulse between edges.
        step(4'b1111, 4'b1111, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_reg", {2'b00, ovf_q, co_q, s_q}, 8'h00);
        check("async_rst_comb", {3'b000, co, s}, 8'h1f);
        rst = 1'b0;
        #1;
        check("post_rst_hold", {2'b00, ovf_q, co_q, s_q}, 8'h00);
        @(posedge clk); #1;
        check("reload", {2'b00, ovf_q, co_q, s_q}, 8'h1f);
        prev_reg = 6'h1f;

        // Full ripple path: ci alone flips every sum bit and the carry.
        step(4'b1111, 4'b0000, 1'b0);
        step(4'b1111, 4'b0000, 1'b1);

        for (int i = 0; i < 200; i++) begin
            step(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
